// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the convolution sequencer.
package conv_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_K_LOAD,
        S_K_READY,
        S_IF_RUN,
        S_DRAIN,
        S_DONE
    } conv_state_e;

    localparam int PIPE_LAT_DEF = 4;

    function automatic int k_words(input int kw, input int kh, input int kc);
        return kw * kh * kc;
    endfunction

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_pos_cnt.sv
// Row/column position counter that wraps at the frame edge; 'last' marks the final position.
module conv_pos_cnt
    import conv_pkg::*;
#(
    parameter int WIDTH  = 128,
    parameter int HEIGHT = 128
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      inc,
    output logic [cnt_w(HEIGHT)-1:0]  row,
    output logic [cnt_w(WIDTH)-1:0]   col,
    output logic                      last
);

    localparam int RW = cnt_w(HEIGHT);
    localparam int CW = cnt_w(WIDTH);

    logic col_end;
    logic row_end;

    assign col_end = (col == CW'(WIDTH - 1));
    assign row_end = (row == RW'(HEIGHT - 1));
    assign last    = col_end && row_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row <= '0;
            col <= '0;
        end else if (clr) begin
            row <= '0;
            col <= '0;
        end else if (inc) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv_ctrl.sv
// Convolution sequencer: kernel prefetch, window streaming, MAC pipe tracking and done pulse.
// Optional CONV_CTRL_PERF_EN adds a saturating perf_cycles counter for the run+drain time.
//
//  state     | meaning
//  ----------+--------------------------------------------------------
//  S_IDLE    | no kernels held; waits for k_prefetch
//  S_K_LOAD  | counting weight beats into the kernel registers
//  S_K_READY | kernels held; if_start runs, k_prefetch reloads
//  S_IF_RUN  | streaming window beats into the MAC array
//  S_DRAIN   | no new beats; waiting for the last pixel to leave the pipe
//  S_DONE    | one-cycle of_done, then back to idle
module conv_ctrl
    import conv_pkg::*;
#(
    parameter int OF_WIDTH  = 128,
    parameter int OF_HEIGHT = 128,
    parameter int K_WIDTH   = 3,
    parameter int K_HEIGHT  = 3,
    parameter int K_CHANNEL = 3,
    parameter int K_NUM     = 3,
    parameter int PIPE_LAT  = PIPE_LAT_DEF
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 k_prefetch,
    input  logic                                                 if_start,
    input  logic [K_NUM-1:0]                                     k_i_valid,
    input  logic                                                 if_i_valid,
    output logic [K_NUM-1:0]                                     k_wr_en,
    output logic [cnt_w(k_words(K_WIDTH, K_HEIGHT, K_CHANNEL))-1:0] k_wr_addr,
    output logic                                                 mac_en,
    output logic [cnt_w(OF_HEIGHT)-1:0]                          of_row,
    output logic [cnt_w(OF_WIDTH)-1:0]                           of_col,
    output logic [K_NUM-1:0]                                     of_o_valid,
    output logic                                                 of_done,
    output logic                                                 busy
`ifdef CONV_CTRL_PERF_EN
    ,
    output logic [31:0]                                          perf_cycles
`endif
);

    localparam int K_WORDS = k_words(K_WIDTH, K_HEIGHT, K_CHANNEL);
    localparam int AW      = cnt_w(K_WORDS);
    localparam int KC_W    = cnt_w(K_WORDS + 1);
    // Every pipe stage except the output one.
    localparam logic [PIPE_LAT-1:0] LOW_MASK = {PIPE_LAT{1'b1}} >> 1;

    conv_state_e state;
    conv_state_e state_nxt;

    logic [KC_W-1:0]     kc [K_NUM];
    logic [K_NUM-1:0]    kc_room;
    logic                kc_full;
    logic                load_start;
    logic                run_start;
    logic                pos_last;
    logic [PIPE_LAT-1:0] vpipe;

    always_comb begin
        kc_full = 1'b1;
        kc_room = '0;
        for (int n = 0; n < K_NUM; n++) begin
            kc_room[n] = (kc[n] < KC_W'(K_WORDS));
            kc_full    = kc_full & (kc[n] == KC_W'(K_WORDS));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        load_start = 1'b0;
        run_start  = 1'b0;
        case (state)
            S_IDLE: begin
                if (k_prefetch) begin
                    state_nxt  = S_K_LOAD;
                    load_start = 1'b1;
                end
            end
            S_K_LOAD: begin
                if (kc_full) state_nxt = S_K_READY;
            end
            S_K_READY: begin
                if (k_prefetch) begin
                    state_nxt  = S_K_LOAD;
                    load_start = 1'b1;
                end else if (if_start) begin
                    state_nxt = S_IF_RUN;
                    run_start = 1'b1;
                end
            end
            S_IF_RUN: begin
                if (mac_en && pos_last) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                // Leave once only the output stage can still hold a pixel.
                if ((vpipe & LOW_MASK) == '0) state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        k_wr_en = (state == S_K_LOAD) ? (k_i_valid & kc_room) : '0;
        mac_en  = (state == S_IF_RUN) && if_i_valid;
        of_done = (state == S_DONE);
        busy    = (state != S_IDLE) && (state != S_K_READY);
    end

    assign k_wr_addr = kc[0][AW-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < K_NUM; n++) kc[n] <= '0;
        end else if (load_start) begin
            for (int n = 0; n < K_NUM; n++) kc[n] <= '0;
        end else if (state == S_K_LOAD) begin
            for (int n = 0; n < K_NUM; n++) begin
                if (k_wr_en[n]) kc[n] <= kc[n] + 1'b1;
            end
        end
    end

    conv_pos_cnt #(
        .WIDTH  (OF_WIDTH),
        .HEIGHT (OF_HEIGHT)
    ) u_pos_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (run_start),
        .inc  (mac_en),
        .row  (of_row),
        .col  (of_col),
        .last (pos_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) vpipe <= '0;
        else     vpipe <= (vpipe << 1) | PIPE_LAT'(mac_en);
    end

    assign of_o_valid = {K_NUM{vpipe[PIPE_LAT-1]}};

`ifdef CONV_CTRL_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_q <= '0;
        end else if (run_start) begin
            perf_q <= '0;
        end else if ((state == S_IF_RUN || state == S_DRAIN) && perf_q != '1) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_conv_ctrl.sv
// Scoreboard bench for conv_ctrl: driver queues expected beats/outputs/done, a negedge monitor checks them.
module tb_conv_ctrl;

    localparam int OF_W     = 128;
    localparam int OF_H     = 128;
    localparam int K_NUM    = 3;
    localparam int K_WORDS  = 27;
    localparam int PIPE_LAT = 4;
    localparam int TOTAL    = OF_W * OF_H;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       k_prefetch = 1'b0;
    logic       if_start = 1'b0;
    logic       if_i_valid = 1'b0;
    logic [2:0] k_i_valid = '0;
    logic [2:0] k_wr_en;
    logic [4:0] k_wr_addr;
    logic       mac_en;
    logic [6:0] of_row;
    logic [6:0] of_col;
    logic [2:0] of_o_valid;
    logic       of_done;
    logic       busy;
`ifdef CONV_CTRL_PERF_EN
    logic [31:0] perf_cycles;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;

    logic [13:0] beat_q[$];
    int          out_q[$];
    int          done_q[$];

    conv_ctrl #(
        .OF_WIDTH  (OF_W),
        .OF_HEIGHT (OF_H),
        .K_WIDTH   (3),
        .K_HEIGHT  (3),
        .K_CHANNEL (3),
        .K_NUM     (K_NUM),
        .PIPE_LAT  (PIPE_LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .k_prefetch (k_prefetch),
        .if_start   (if_start),
        .k_i_valid  (k_i_valid),
        .if_i_valid (if_i_valid),
        .k_wr_en    (k_wr_en),
        .k_wr_addr  (k_wr_addr),
        .mac_en     (mac_en),
        .of_row     (of_row),
        .of_col     (of_col),
        .of_o_valid (of_o_valid),
        .of_done    (of_done),
        .busy       (busy)
`ifdef CONV_CTRL_PERF_EN
        ,
        .perf_cycles(perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every DUT event must match the head of its queue.
    always @(negedge clk) begin
        if (mac_en) begin
            if (beat_q.size() == 0) chk("unexpected_mac_en", mac_en, 0);
            else                    chk("beat_row_col", {of_row, of_col}, beat_q.pop_front());
        end
        if (of_o_valid != '0) begin
            if (out_q.size() == 0) begin
                chk("unexpected_of_o_valid", of_o_valid, 0);
            end else begin
                chk("of_o_valid_cycle", cyc, out_q.pop_front());
                chk("of_o_valid_value", of_o_valid, 3'b111);
            end
        end
        if (of_done) begin
            done_cnt++;
            if (done_q.size() == 0) chk("unexpected_of_done", of_done, 0);
            else                    chk("of_done_cycle", cyc, done_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_prefetch();
        tick();
        k_prefetch = 1'b1;
        tick();
        k_prefetch = 1'b0;
    endtask

    task automatic load_beats();
        for (int i = 0; i < K_WORDS; i++) begin
            k_i_valid = 3'b111;
            @(negedge clk);
            chk("k_wr_en_beat", k_wr_en, 3'b111);
            chk("k_wr_addr", k_wr_addr, i);
            tick();
        end
        k_i_valid = 3'b111;
        @(negedge clk);
        chk("k_wr_en_extra_valid", k_wr_en, 0);
        chk("busy_load_full", busy, 1);
        tick();
        k_i_valid = '0;
        @(negedge clk);
        chk("busy_k_ready", busy, 0);
    endtask

    task automatic run_frame(input bit bubbles, input int stop_at);
        int r = 0;
        int c = 0;
        int n = 0;
        bit v;
        tick();
        if_start = 1'b1;
        tick();
        if_start = 1'b0;
        while (n < TOTAL && n != stop_at) begin
            v = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
            if_i_valid = v;
            if (v) begin
                beat_q.push_back({7'(r), 7'(c)});
                out_q.push_back(cyc + PIPE_LAT);
                n++;
                if (n == TOTAL) done_q.push_back(cyc + PIPE_LAT + 1);
                if (c == OF_W - 1) begin
                    c = 0;
                    r++;
                end else begin
                    c++;
                end
            end
            tick();
        end
        if_i_valid = 1'b0;
        if (n == TOTAL) begin
            @(negedge clk);
            chk("busy_drain", busy, 1);
        end
    endtask

    task automatic wait_done(input int target);
        int k = 0;
        while (done_cnt < target && k < 64) begin
            @(negedge clk);
            k++;
        end
        chk("of_done_count", done_cnt, target);
        tick();
        @(negedge clk);
        chk("busy_after_done", busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held 10 cycles, then if_start in IDLE must do nothing.
        rst = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("rst_k_wr_en", k_wr_en, 0);
        chk("rst_k_wr_addr", k_wr_addr, 0);
        chk("rst_mac_en", mac_en, 0);
        chk("rst_of_row_col", {of_row, of_col}, 0);
        chk("rst_of_o_valid", of_o_valid, 0);
        chk("rst_of_done", of_done, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        if_start = 1'b1;
        tick();
        if_start = 1'b0;
        if_i_valid = 1'b1;
        @(negedge clk);
        chk("idle_if_start_busy", busy, 0);
        chk("idle_if_start_mac_en", mac_en, 0);
        tick();
        @(negedge clk);
        chk("idle_stays_idle", busy, 0);
        tick();
        if_i_valid = 1'b0;

        // Kernel prefetch.
        pulse_prefetch();
        load_beats();

        // Simultaneous k_prefetch and if_start in K_READY: reload wins.
        tick();
        k_prefetch = 1'b1;
        if_start = 1'b1;
        tick();
        k_prefetch = 1'b0;
        if_start = 1'b0;
        if_i_valid = 1'b1;
        @(negedge clk);
        chk("both_pulse_busy", busy, 1);
        chk("both_pulse_mac_en", mac_en, 0);
        tick();
        if_i_valid = 1'b0;
        load_beats();

        // Full frame, valid every cycle.
        run_frame(1'b0, -1);
        wait_done(1);
`ifdef CONV_CTRL_PERF_EN
        chk("perf_cycles_full_frame", perf_cycles, TOTAL + PIPE_LAT);
`endif

        // Second back-to-back iteration with 50% bubbles.
        pulse_prefetch();
        load_beats();
        run_frame(1'b1, -1);
        wait_done(2);

        // Reset in the middle of a frame.
        pulse_prefetch();
        load_beats();
        run_frame(1'b0, 5000);
        rst = 1'b1;
        beat_q.delete();
        out_q.delete();
        done_q.delete();
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_mac_en", mac_en, 0);
        chk("midrst_of_o_valid", of_o_valid, 0);
        chk("midrst_row_col", {of_row, of_col}, 0);
        @(negedge clk);
        chk("midrst_of_o_valid_next", of_o_valid, 0);
        tick();
        tick();
        rst = 1'b0;

        // Clean rerun after reset.
        pulse_prefetch();
        load_beats();
        run_frame(1'b0, -1);
        wait_done(3);

        chk("beat_q_empty", beat_q.size(), 0);
        chk("out_q_empty", out_q.size(), 0);
        chk("done_q_empty", done_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
